// File: rtl/dvp_ddr3_csr.sv
// Per-channel capture CSRs (Avalon-MM) with ping-pong bases and a frame-marker driven capture FSM.
// Writes land next cycle, reads return one cycle later with no waitrequest; irq is a registered level.
module dvp_ddr3_csr #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int ADDR_W  = CH_BITS + 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic                  avs_write,
    input  logic                  avs_read,
    input  logic [DATA_W-1:0]     avs_writedata,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    input  logic [NUM_CH-1:0]     frame_start,
    input  logic [NUM_CH-1:0]     frame_end,
    output logic [NUM_CH-1:0]     cap_en,
    output logic [NUM_CH*32-1:0]  cap_base,
    output logic [NUM_CH*32-1:0]  cap_size,
    output logic                  irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] buf0;
        logic [31:0] buf1;
        logic [31:0] img_size;
        logic [2:0]  ctrl;
        state_t      state;
        logic        act;
        logic [1:0]  stat;
        logic [1:0]  mask;
        logic [31:0] cnt;
        logic [31:0] base;
        logic [31:0] size;
    } ch_t;

    ch_t ch_q [NUM_CH];
    ch_t ch_d [NUM_CH];

    logic [CH_BITS-1:0] acc_ch;
    logic [2:0]         acc_off;
    logic               hit      [NUM_CH];
    logic               ctrl_wr  [NUM_CH];
    logic [2:0]         ctrl_new [NUM_CH];
    logic [1:0]         w1c      [NUM_CH];
    logic               done     [NUM_CH];
    logic               drop     [NUM_CH];
    logic               relatch  [NUM_CH];
    logic               hw_clr   [NUM_CH];
    logic [31:0]        rd_mux;
    logic               irq_d;

    assign acc_ch  = avs_address[ADDR_W-1:3];
    assign acc_off = avs_address[2:0];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
        return res;
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_d[c]     = ch_q[c];
            hit[c]      = avs_write && (acc_ch == CH_BITS'(c));
            ctrl_wr[c]  = hit[c] && (acc_off == 3'd3);
            ctrl_new[c] = avs_byteenable[0] ? avs_writedata[2:0] : ch_q[c].ctrl;
            w1c[c]      = (hit[c] && acc_off == 3'd5 && avs_byteenable[0]) ? avs_writedata[1:0] : 2'b00;
            done[c]     = 1'b0;
            drop[c]     = 1'b0;
            relatch[c]  = 1'b0;
            hw_clr[c]   = 1'b0;

            if (hit[c]) begin
                case (acc_off)
                    3'd0: ch_d[c].buf0     = merge(ch_q[c].buf0, avs_writedata, avs_byteenable);
                    3'd1: ch_d[c].buf1     = merge(ch_q[c].buf1, avs_writedata, avs_byteenable);
                    3'd2: ch_d[c].img_size = merge(ch_q[c].img_size, avs_writedata, avs_byteenable);
                    3'd6: if (avs_byteenable[0]) ch_d[c].mask = avs_writedata[1:0];
                    default: ;
                endcase
            end

            case (ch_q[c].state)
                ST_ARMED: if (frame_start[c]) begin
                    ch_d[c].state = ST_BUSY;
                    relatch[c]    = 1'b1;
                end
                ST_BUSY: if (frame_end[c]) begin
                    done[c] = 1'b1;
                    if (ch_q[c].ctrl[2]) ch_d[c].act = ~ch_q[c].act;
                    // A start coinciding with the end rolls straight into the next frame when continuous.
                    if (ch_q[c].ctrl[1]) begin
                        ch_d[c].state = frame_start[c] ? ST_BUSY : ST_ARMED;
                        relatch[c]    = frame_start[c];
                    end else begin
                        ch_d[c].state = ST_IDLE;
                        hw_clr[c]     = 1'b1;
                        drop[c]       = frame_start[c];
                    end
                end else if (frame_start[c]) begin
                    drop[c] = 1'b1;
                end
                default: ;
            endcase

            if (ctrl_wr[c]) begin
                ch_d[c].ctrl = ctrl_new[c];
                if (!ctrl_new[c][0]) begin
                    ch_d[c].state = ST_IDLE;
                    ch_d[c].act   = ch_q[c].act;
                    done[c]       = 1'b0;
                    drop[c]       = 1'b0;
                    relatch[c]    = 1'b0;
                end else if (ch_d[c].state == ST_IDLE) begin
                    ch_d[c].state = ST_ARMED;
                end
                if (!ctrl_new[c][2]) ch_d[c].act = 1'b0;
            end else if (hw_clr[c]) begin
                ch_d[c].ctrl[0] = 1'b0;
            end

            ch_d[c].stat = (ch_q[c].stat & ~w1c[c]) | {drop[c], done[c]};
            if (done[c]) ch_d[c].cnt = ch_q[c].cnt + 32'd1;
            if (relatch[c]) begin
                ch_d[c].base = ch_d[c].act ? ch_q[c].buf1 : ch_q[c].buf0;
                ch_d[c].size = ch_q[c].img_size;
            end
        end
    end

    always_comb begin
        cap_en   = '0;
        cap_base = '0;
        cap_size = '0;
        irq_d    = 1'b0;
        rd_mux   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cap_en[c]            = (ch_q[c].state == ST_BUSY);
            cap_base[32*c +: 32] = ch_q[c].base;
            cap_size[32*c +: 32] = ch_q[c].size;
            irq_d                = irq_d | (|(ch_q[c].stat & ch_q[c].mask));
            if (acc_ch == CH_BITS'(c)) begin
                case (acc_off)
                    3'd0:    rd_mux = ch_q[c].buf0;
                    3'd1:    rd_mux = ch_q[c].buf1;
                    3'd2:    rd_mux = ch_q[c].img_size;
                    3'd3:    rd_mux = {29'd0, ch_q[c].ctrl};
                    3'd4:    rd_mux = {29'd0, ch_q[c].act, ch_q[c].state};
                    3'd5:    rd_mux = {30'd0, ch_q[c].stat};
                    3'd6:    rd_mux = {30'd0, ch_q[c].mask};
                    default: rd_mux = ch_q[c].cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) ch_q[c] <= '0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            irq               <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) ch_q[c] <= ch_d[c];
            avs_readdata      <= avs_read ? rd_mux : '0;
            avs_readdatavalid <= avs_read;
            irq               <= irq_d;
        end
    end

endmodule

// File: tb/tb_dvp_ddr3_csr.sv
// Scoreboarded bench for dvp_ddr3_csr: directed scenarios plus random traffic against an event-level model.
module tb_dvp_ddr3_csr;
    localparam int NCH = 3;
    localparam int AW  = 5;
    localparam int IDLE = 0, ARMED = 1, BUSY = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     avs_address;
    logic              avs_write, avs_read;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;
    logic [NCH-1:0]    frame_start, frame_end, cap_en;
    logic [NCH*32-1:0] cap_base, cap_size;
    logic              irq;

    always #5 clk = ~clk;

    dvp_ddr3_csr #(.NUM_CH(NCH), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .avs_address(avs_address), .avs_write(avs_write),
        .avs_read(avs_read), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .frame_start(frame_start), .frame_end(frame_end), .cap_en(cap_en),
        .cap_base(cap_base), .cap_size(cap_size), .irq(irq)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; int due; int ch; int off; } rd_t;
    rd_t sb_q[$];
    rd_t mon_e;

    // Reference state, one entry per implemented channel.
    logic [31:0] m_buf0[NCH], m_buf1[NCH], m_size[NCH], m_cnt[NCH], m_obase[NCH], m_osize[NCH];
    logic [2:0]  m_ctrl[NCH];
    int          m_state[NCH];
    logic        m_act[NCH];
    logic [1:0]  m_stat[NCH], m_mask[NCH];
    logic        exp_irq;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bemerge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] keep;
        keep = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (d & keep) | (old & ~keep);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_buf0[c] = 0; m_buf1[c] = 0; m_size[c] = 0; m_cnt[c] = 0;
            m_obase[c] = 0; m_osize[c] = 0; m_ctrl[c] = 0; m_state[c] = IDLE;
            m_act[c] = 0; m_stat[c] = 0; m_mask[c] = 0;
        end
        exp_irq = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input int ch, input int off);
        if (ch >= NCH) return 32'd0;
        case (off)
            0: return m_buf0[ch];
            1: return m_buf1[ch];
            2: return m_size[ch];
            3: return {29'd0, m_ctrl[ch]};
            4: return {29'd0, m_act[ch], 2'(m_state[ch])};
            5: return {30'd0, m_stat[ch]};
            6: return {30'd0, m_mask[ch]};
            default: return m_cnt[ch];
        endcase
    endfunction

    function automatic logic model_irq();
        logic r;
        r = 1'b0;
        for (int c = 0; c < NCH; c++) r = r | (|(m_stat[c] & m_mask[c]));
        return r;
    endfunction

    // Events are handled in order: W1C, frame end, frame start, then the register write.
    task automatic model_cycle(input bit wr, input int ch, input int off, input logic [31:0] d,
                               input logic [3:0] be, input logic [NCH-1:0] fs, input logic [NCH-1:0] fe);
        for (int c = 0; c < NCH; c++) begin
            bit mine, abort, finished;
            logic [2:0] nctrl;
            mine     = wr && (ch == c);
            nctrl    = be[0] ? d[2:0] : m_ctrl[c];
            abort    = mine && (off == 3) && !nctrl[0];
            finished = 0;
            if (mine && off == 5 && be[0]) m_stat[c] = m_stat[c] & ~d[1:0];
            if (!abort) begin
                if (fe[c] && m_state[c] == BUSY) begin
                    m_stat[c][0] = 1'b1;
                    m_cnt[c]     = m_cnt[c] + 1;
                    if (m_ctrl[c][2]) m_act[c] = !m_act[c];
                    if (m_ctrl[c][1]) m_state[c] = ARMED;
                    else begin
                        m_state[c]   = IDLE;
                        m_ctrl[c][0] = 1'b0;
                        finished     = 1;
                    end
                end
                if (fs[c]) begin
                    if (m_state[c] == ARMED) begin
                        m_state[c] = BUSY;
                        m_obase[c] = m_act[c] ? m_buf1[c] : m_buf0[c];
                        m_osize[c] = m_size[c];
                    end else if (m_state[c] == BUSY || finished) begin
                        m_stat[c][1] = 1'b1;
                    end
                end
            end
            if (mine) begin
                case (off)
                    0: m_buf0[c] = bemerge(m_buf0[c], d, be);
                    1: m_buf1[c] = bemerge(m_buf1[c], d, be);
                    2: m_size[c] = bemerge(m_size[c], d, be);
                    3: begin
                        m_ctrl[c] = nctrl;
                        if (abort) m_state[c] = IDLE;
                        else if (m_state[c] == IDLE) m_state[c] = ARMED;
                        if (!nctrl[2]) m_act[c] = 1'b0;
                    end
                    6: if (be[0]) m_mask[c] = d[1:0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_outputs();
        logic [NCH-1:0]    een;
        logic [NCH*32-1:0] eb, es;
        for (int c = 0; c < NCH; c++) begin
            een[c]         = (m_state[c] == BUSY);
            eb[32*c +: 32] = m_obase[c];
            es[32*c +: 32] = m_osize[c];
        end
        check("cap_en", cap_en, een);
        check("cap_base", cap_base, eb);
        check("cap_size", cap_size, es);
        check("irq", irq, exp_irq);
    endtask

    task automatic tick();
        @(negedge clk);
        avs_write   = 1'b0;
        avs_read    = 1'b0;
        frame_start = '0;
        frame_end   = '0;
        check_outputs();
    endtask

    task automatic cycle(input bit wr, input bit rd, input int ch, input int off, input logic [31:0] d,
                         input logic [3:0] be, input logic [NCH-1:0] fs, input logic [NCH-1:0] fe);
        rd_t e;
        avs_address    = {2'(ch), 3'(off)};
        avs_write      = wr;
        avs_read       = rd;
        avs_writedata  = d;
        avs_byteenable = be;
        frame_start    = fs;
        frame_end      = fe;
        if (rd) begin
            e.data = model_read(ch, off); e.due = cyc + 1; e.ch = ch; e.off = off;
            sb_q.push_back(e);
        end
        exp_irq = model_irq();
        model_cycle(wr, ch, off, d, be, fs, fe);
        tick();
    endtask

    task automatic wr(input int ch, input int off, input logic [31:0] d);
        cycle(1, 0, ch, off, d, 4'hF, '0, '0);
    endtask
    task automatic wrb(input int ch, input int off, input logic [31:0] d, input logic [3:0] be);
        cycle(1, 0, ch, off, d, be, '0, '0);
    endtask
    task automatic rd(input int ch, input int off);
        cycle(0, 1, ch, off, 32'd0, 4'h0, '0, '0);
    endtask
    task automatic ev(input int c, input bit s, input bit e);
        logic [NCH-1:0] vs, ve;
        vs = '0; ve = '0;
        vs[c] = s; ve[c] = e;
        cycle(0, 0, 0, 0, 32'd0, 4'h0, vs, ve);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'd0, 4'h0, '0, '0);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask
    task automatic read_all();
        for (int c = 0; c < 4; c++)
            for (int o = 0; o < 8; o++) rd(c, o);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                mon_e = sb_q.pop_front();
                total++;
                if (mon_e.due != cyc || avs_readdatavalid !== 1'b1 || avs_readdata !== mon_e.data) begin
                    bad++;
                    $display("FAIL rd ch%0d off%0d: got vld=%b dat=%h want vld=1 dat=%h",
                             mon_e.ch, mon_e.off, avs_readdatavalid, avs_readdata, mon_e.data);
                end
            end else begin
                total++;
                if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'd0) begin
                    bad++;
                    $display("FAIL bus_idle: got vld=%b dat=%h want vld=0 dat=0",
                             avs_readdatavalid, avs_readdata);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, rc, ro;
        logic [31:0] rdat;
        logic [3:0]  rbe;
        logic [NCH-1:0] vs, ve;

        rst = 1'b1; avs_address = '0; avs_write = 0; avs_read = 0;
        avs_writedata = '0; avs_byteenable = '0; frame_start = '0; frame_end = '0;
        do_reset();
        mon_on = 1'b1;

        read_all();

        // Single-shot capture on ch1.
        wr(1, 0, 32'h1000_0000); wr(1, 2, 32'h0004_B000); wr(1, 3, 32'h1);
        rd(1, 4);
        ev(1, 1, 0);
        check("ch1_base", cap_base[63:32], 32'h1000_0000);
        check("ch1_en", cap_en[1], 1'b1);
        ev(1, 0, 1);
        check("ch1_en_done", cap_en[1], 1'b0);
        rd(1, 3); rd(1, 4); rd(1, 7); rd(1, 5);

        // Continuous ping-pong on ch0.
        wr(0, 0, 32'h100); wr(0, 1, 32'h200); wr(0, 3, 32'h7);
        for (int f = 0; f < 3; f++) begin
            ev(0, 1, 0);
            check($sformatf("pp_base%0d", f), cap_base[31:0], (f == 1) ? 32'h200 : 32'h100);
            idle(2);
            ev(0, 0, 1);
            rd(0, 4);
        end
        rd(0, 7);

        // Interrupt timing and W1C against a simultaneous set.
        wr(0, 5, 32'h3); wr(0, 6, 32'h1);
        ev(0, 1, 0); idle(1);
        ev(0, 0, 1);
        check("irq_t1", irq, 1'b0);
        idle(1);
        check("irq_t2", irq, 1'b1);
        ev(0, 1, 0);
        cycle(1, 0, 0, 5, 32'h1, 4'hF, '0, 3'b001);
        idle(2);
        check("irq_setwins", irq, 1'b1);
        rd(0, 5);
        wr(0, 5, 32'h1);
        check("irq_w1c_t1", irq, 1'b1);
        idle(1);
        check("irq_w1c_t2", irq, 1'b0);
        wr(0, 3, 32'h0); rd(0, 4);

        // Dropped frame, then abort.
        wr(2, 0, 32'hA000); wr(2, 3, 32'h1);
        ev(2, 1, 0); ev(2, 1, 0);
        check("drop_base", cap_base[95:64], 32'hA000);
        rd(2, 5);
        wr(2, 3, 32'h0); rd(2, 4); rd(2, 7);

        // Byte lanes and out-of-range channel.
        wr(2, 0, 32'h1122_3344); wrb(2, 0, 32'hAABB_CCDD, 4'h3); rd(2, 0);
        wr(3, 0, 32'hDEAD_BEEF); rd(3, 0); rd(2, 0); rd(0, 0); rd(1, 0);

        // CTRL write colliding with a hardware enable clear.
        wr(1, 3, 32'h1); ev(1, 1, 0);
        cycle(1, 0, 1, 3, 32'h1, 4'hF, '0, 3'b010);
        rd(1, 4); rd(1, 3); rd(1, 7); rd(1, 5);
        wr(1, 3, 32'h0);

        // Read and write in the same cycle.
        cycle(1, 1, 2, 1, 32'h5555_AAAA, 4'hF, '0, '0);
        rd(2, 1);

        // Start and end together: continuous, then single-shot.
        wr(0, 3, 32'h7); ev(0, 1, 0); ev(0, 1, 1);
        check("same_cyc_base", cap_base[31:0], 32'h200);
        rd(0, 4);
        wr(0, 3, 32'h0); wr(0, 5, 32'h3); wr(0, 3, 32'h1);
        ev(0, 1, 0); ev(0, 1, 1);
        rd(0, 5); rd(0, 4); rd(0, 3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 9); rc = $urandom_range(0, 3); ro = $urandom_range(0, 7);
            rdat = $urandom; rbe = 4'($urandom_range(0, 15));
            if (ro == 3) rbe[0] = 1'b1;
            case (op)
                0, 1, 2: wrb(rc, ro, rdat, rbe);
                3, 4:    rd(rc, ro);
                5:       ev(rc % NCH, 1, 0);
                6:       ev(rc % NCH, 0, 1);
                7:       ev(rc % NCH, 1, 1);
                8: begin
                    vs = 3'($urandom); ve = 3'($urandom);
                    cycle(0, 0, 0, 0, 32'd0, 4'h0, vs, ve);
                end
                default: cycle(1, 1, rc, ro, rdat, rbe, '0, '0);
            endcase
        end
        read_all();

        // Reset mid-frame, then a stale frame_end.
        wr(0, 3, 32'h1); ev(0, 1, 0); idle(1);
        do_reset();
        ev(0, 0, 1);
        rd(0, 4); rd(0, 7); rd(0, 5); rd(0, 3);

        idle(3);
        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
